mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Burst initiator for the 16×16-bit register-bank memory. It accepts load/store burst commands from the CPU datapath, drives the memory's address / data_in / write_enable port, and returns read data as a valid/ready stream. It sits between the control unit and the memory, replacing direct datapath drive of the memory port.

## Interface
Parameters: none. Memory geometry is fixed at 16 words × 16 bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle; command accepted on cmd_valid & cmd_ready
- cmd_write  in  1  1 = store burst, 0 = load burst
- cmd_addr  in  4  start word address
- cmd_len  in  4  beats minus one (0 → 1 beat, 15 → 16 beats)
- wr_data  in  16  store data stream
- wr_valid  in  1  store beat offered
- wr_ready  out  1  store beat accepted on wr_valid & wr_ready
- rd_data  out  16  load data, registered
- rd_valid  out  1  load beat presented
- rd_ready  in  1  load beat consumed on rd_valid & rd_ready
- done  out  1  one-cycle pulse, burst complete
- mem_address  out  4  to memory address
- mem_data_in  out  16  to memory data_in
- mem_write_enable  out  1  to memory write_enable
- mem_data_out  in  16  from memory data_out (combinational read)

## Operation
- States: IDLE, WRITE, READ, FLUSH, DONE.
- IDLE: cmd_ready=1. On the command handshake: addr_q←cmd_addr, left_q←cmd_len, go to WRITE if cmd_write, else READ.
- mem_address = addr_q at all times. mem_data_in = wr_data at all times.
- WRITE: wr_ready=1; mem_write_enable = wr_valid (combinational, asserted only in WRITE). Each store handshake writes wr_data to mem[addr_q] on that edge and sets addr_q←addr_q+1 (mod 16). If left_q==0 → DONE, else left_q−1. A wr_valid gap stalls; there is no timeout.
- READ: when !rd_valid | rd_ready, the controller captures rd_data←mem_data_out, sets rd_valid←1 and addr_q+1 (mod 16). If left_q==0 → FLUSH, else left_q−1. Otherwise it holds rd_data, rd_valid and addr_q.
- FLUSH: no memory activity. When rd_valid & rd_ready: rd_valid←0 → DONE.
- DONE: done=1 for exactly one cycle → IDLE. cmd_ready=0 in DONE.
- Address wrap: 15+1→0. A 16-beat burst from any address touches every word exactly once.
- mem_write_enable is never asserted outside WRITE. cmd_* inputs are ignored outside IDLE.
- rd_data and rd_valid never change while rd_valid=1 and rd_ready=0.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, addr_q=0, left_q=0, rd_data=0, rd_valid=0. Resulting outputs: cmd_ready=1, wr_ready=0, done=0, mem_address=0, mem_write_enable=0.
- Reset mid-burst aborts immediately. Store words already written stay written, and no further write occurs. A pending load beat is dropped with no done pulse.
- Store throughput: 1 beat/cycle with wr_valid held high. N-beat store: command edge E0, beats on edges E1..EN, done high in cycle after EN, cmd_ready high the cycle after that.
- Load latency: command edge E0; first capture at E1 (rd_valid high after E1). With rd_ready held high: 1 beat/cycle, last beat consumed at EN+1, done high in the following cycle.
- Back-pressure: rd_ready low stalls capture and the address advance; data is not lost or duplicated.
- Memory write lands at the same edge as the wr handshake. A load issued right after a store observes the stored data.

## Test plan
- Reset with every input asserted → cmd_ready=1, rd_valid=0, mem_write_enable=0, mem_address=0, done=0.
- Store cmd_addr=3, cmd_len=2, wr_data 0xAAAA/0xBBBB/0xCCCC back-to-back → mem[3..5] hold those values, done pulses once 1 cycle after 3rd beat, other words unchanged.
- Store wrap: cmd_addr=14, cmd_len=3, data 1,2,3,4 → mem[14]=1, mem[15]=2, mem[0]=3, mem[1]=4. Then load cmd_addr=14, cmd_len=3, rd_ready=1 → rd_data sequence 1,2,3,4 on consecutive cycles, done pulses once.
- Load 16 beats from 0 with rd_ready toggling 1,0,0,1… → exactly 16 beats in address order, rd_data stable while stalled, no duplicates.
- Store with wr_valid gaps (beat, 2 idle cycles, beat) → mem_write_enable low during gaps, two words written, done pulses after the second.
- Drive reset low during the 2nd beat of a 4-beat store → only beat 1 written, outputs at reset values, no done pulse; next command then executes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Burst initiator for the 16 x 16-bit register-bank memory. It takes
//   load/store burst commands, drives the memory address/data/write-enable
//   port, and returns load data as a registered valid/ready stream.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake (cmd_ready only in IDLE)
//   cmd_write           1 = store burst, 0 = load burst
//   cmd_addr, cmd_len   start word address, beats minus one
//   wr_data/wr_valid/wr_ready   store data stream
//   rd_data/rd_valid/rd_ready   load data stream (registered)
//   done                one-cycle pulse when a burst completes
//   mem_address/mem_data_in/mem_write_enable/mem_data_out   memory port
//   o_dbg_state         current FSM state (IDLE=0 WRITE=1 READ=2 FLUSH=3 DONE=4)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds its valid and its data stable until that edge.
// The consumer may raise or drop ready at any time.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        done,
    output logic [3:0]  mem_address,
    output logic [15:0] mem_data_in,
    output logic        mem_write_enable,
    input  logic [15:0] mem_data_out,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_addr;
    logic [3:0]  r_left;
    logic [15:0] r_rd_data;
    logic        r_rd_valid;

    logic        w_cmd_fire;
    logic        w_wr_fire;
    logic        w_rd_capture;
    logic        w_rd_drain;

    assign w_cmd_fire   = (r_state == S_IDLE)  && cmd_valid;
    assign w_wr_fire    = (r_state == S_WRITE) && wr_valid;
    // A new beat may be captured when the output register is empty or its
    // current beat is being consumed on this same edge.
    assign w_rd_capture = (r_state == S_READ)  && (!r_rd_valid || rd_ready);
    assign w_rd_drain   = (r_state == S_FLUSH) && r_rd_valid && rd_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_next_state = cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (wr_valid && (r_left == 4'd0)) begin
                    w_next_state = S_DONE;
                end
            end
            S_READ: begin
                if (w_rd_capture && (r_left == 4'd0)) begin
                    w_next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_rd_drain) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready        = (r_state == S_IDLE);
        wr_ready         = (r_state == S_WRITE);
        mem_write_enable = w_wr_fire;
        done             = (r_state == S_DONE);
    end

    // Burst address / beat counter / read output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= 4'd0;
            r_left     <= 4'd0;
            r_rd_data  <= 16'd0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_addr <= cmd_addr;
                r_left <= cmd_len;
            end
            // 4-bit address wraps 15 -> 0 naturally.
            if (w_wr_fire || w_rd_capture) begin
                r_addr <= r_addr + 4'd1;
                if (r_left != 4'd0) begin
                    r_left <= r_left - 4'd1;
                end
            end
            if (w_rd_capture) begin
                r_rd_data  <= mem_data_out;
                r_rd_valid <= 1'b1;
            end
            if (w_rd_drain) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign mem_address = r_addr;
    assign mem_data_in = wr_data;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a behavioural 16 x 16 memory
// (combinational read, write on the rising edge).
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        done;
    logic [3:0]  mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write_enable;
    logic [15:0] mem_data_out;
    logic [2:0]  dbg_state;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [15:0] mem [16];
    logic        mem_loaded = 1'b0;
    logic [15:0] exp_mem [16];
    logic [15:0] exp_q [$];
    logic [15:0] wbuf [16];

    mem_access_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .wr_data          (wr_data),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .done             (done),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out),
        .o_dbg_state      (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preloaded with 0x1000+i on the first edge.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
            mem_loaded <= 1'b1;
        end else if (mem_write_enable) begin
            mem[mem_address] <= mem_data_in;
        end
    end
    assign mem_data_out = mem[mem_address];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) check(tag, mem[i], exp_mem[i]);
    endtask

    task automatic send_cmd(input logic w, input logic [3:0] a, input logic [3:0] l);
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("cmd_ready_wait", 16'(cmd_ready), 16'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
    endtask

    // Back-to-back store of wbuf[0..n-1]
    task automatic store_burst(input logic [3:0] a, input int n);
        logic [3:0] ea;
        send_cmd(1'b1, a, 4'(n - 1));
        for (int i = 0; i < n; i++) begin
            ea       = a + 4'(i);
            wr_data  = wbuf[i];
            wr_valid = 1'b1;
            #1;
            check("st_wr_ready", 16'(wr_ready), 16'd1);
            check("st_we", 16'(mem_write_enable), 16'd1);
            check("st_addr", 16'(mem_address), 16'(ea));
            check("st_no_early_done", 16'(done), 16'd0);
            exp_mem[ea] = wbuf[i];
            tick();
        end
        wr_valid = 1'b0;
        #1;
        check("st_done", 16'(done), 16'd1);
        check("st_cmd_ready_in_done", 16'(cmd_ready), 16'd0);
        check("st_we_after", 16'(mem_write_enable), 16'd0);
        tick();
        check("st_done_clear", 16'(done), 16'd0);
        check("st_idle", 16'(cmd_ready), 16'd1);
    endtask

    // Load with rd_ready held high
    task automatic load_burst(input logic [3:0] a, input int n);
        logic [3:0] ea;
        send_cmd(1'b0, a, 4'(n - 1));
        rd_ready = 1'b1;
        #1;
        check("ld_valid_e0", 16'(rd_valid), 16'd0);
        for (int i = 0; i < n; i++) begin
            ea = a + 4'(i);
            tick();
            check("ld_valid", 16'(rd_valid), 16'd1);
            check("ld_data", rd_data, exp_mem[ea]);
            check("ld_no_early_done", 16'(done), 16'd0);
        end
        tick();
        check("ld_valid_drop", 16'(rd_valid), 16'd0);
        check("ld_done", 16'(done), 16'd1);
        tick();
        check("ld_done_clear", 16'(done), 16'd0);
        check("ld_idle", 16'(cmd_ready), 16'd1);
        rd_ready = 1'b0;
    endtask

    initial begin
        int          beats;
        int          got_done;
        int          stalled;
        logic [15:0] held;
        logic [15:0] want;

        for (int i = 0; i < 16; i++) exp_mem[i] = 16'h1000 + 16'(i);

        // Reset with every input asserted
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'hF;
        cmd_len   = 4'hF;
        wr_data   = 16'hFFFF;
        wr_valid  = 1'b1;
        rd_ready  = 1'b1;
        repeat (3) tick();
        check("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        check("rst_rd_valid", 16'(rd_valid), 16'd0);
        check("rst_rd_data", rd_data, 16'h0000);
        check("rst_we", 16'(mem_write_enable), 16'd0);
        check("rst_addr", 16'(mem_address), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_wr_ready", 16'(wr_ready), 16'd0);
        check("rst_state", 16'(dbg_state), 16'd0);
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'd0;
        cmd_len   = 4'd0;
        wr_data   = 16'd0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_mem("mem_preload");

        // Store 3 beats at address 3
        wbuf[0] = 16'hAAAA;
        wbuf[1] = 16'hBBBB;
        wbuf[2] = 16'hCCCC;
        store_burst(4'd3, 3);
        check_mem("mem_after_store3");

        // Store with address wrap, then read back
        wbuf[0] = 16'd1;
        wbuf[1] = 16'd2;
        wbuf[2] = 16'd3;
        wbuf[3] = 16'd4;
        store_burst(4'd14, 4);
        check("wrap_m14", mem[14], 16'd1);
        check("wrap_m15", mem[15], 16'd2);
        check("wrap_m0", mem[0], 16'd3);
        check("wrap_m1", mem[1], 16'd4);
        check_mem("mem_after_wrap");
        load_burst(4'd14, 4);

        // 16-beat load with rd_ready pattern 1,0,0,1,0,0...
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_mem[i]);
        send_cmd(1'b0, 4'd0, 4'd15);
        beats    = 0;
        got_done = 0;
        stalled  = 0;
        held     = 16'd0;
        for (int c = 0; c < 200 && got_done == 0; c++) begin
            rd_ready = (c % 3 == 0);
            #1;
            if (done) begin
                got_done = 1;
            end else begin
                if (stalled != 0) begin
                    check("tog_stall_valid", 16'(rd_valid), 16'd1);
                    check("tog_stall_data", rd_data, held);
                end
                if (rd_valid && rd_ready) begin
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                    check("tog_data", rd_data, want);
                    beats++;
                    stalled = 0;
                end else if (rd_valid) begin
                    stalled = 1;
                    held    = rd_data;
                end else begin
                    stalled = 0;
                end
            end
            tick();
        end
        check("tog_done_seen", 16'(got_done), 16'd1);
        check("tog_beats", 16'(beats), 16'd16);
        check("tog_queue_empty", 16'(exp_q.size()), 16'd0);
        check("tog_done_clear", 16'(done), 16'd0);
        check("tog_idle", 16'(cmd_ready), 16'd1);
        rd_ready = 1'b0;

        // Store with wr_valid gaps: beat, 2 idle cycles, beat
        send_cmd(1'b1, 4'd8, 4'd1);
        wr_data  = 16'h1111;
        wr_valid = 1'b1;
        #1;
        check("gap_we_beat1", 16'(mem_write_enable), 16'd1);
        exp_mem[8] = 16'h1111;
        tick();
        wr_valid = 1'b0;
        wr_data  = 16'h9999;
        for (int g = 0; g < 2; g++) begin
            #1;
            check("gap_we_low", 16'(mem_write_enable), 16'd0);
            check("gap_wr_ready", 16'(wr_ready), 16'd1);
            check("gap_no_done", 16'(done), 16'd0);
            tick();
        end
        wr_data  = 16'h2222;
        wr_valid = 1'b1;
        #1;
        check("gap_we_beat2", 16'(mem_write_enable), 16'd1);
        check("gap_addr_beat2", 16'(mem_address), 16'd9);
        exp_mem[9] = 16'h2222;
        tick();
        wr_valid = 1'b0;
        #1;
        check("gap_done", 16'(done), 16'd1);
        tick();
        check("gap_done_clear", 16'(done), 16'd0);
        check_mem("mem_after_gap");

        // Reset during 2nd beat of a 4-beat store at address 10
        send_cmd(1'b1, 4'd10, 4'd3);
        wr_data  = 16'h5555;
        wr_valid = 1'b1;
        exp_mem[10] = 16'h5555;
        tick();
        wr_data  = 16'h6666;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_cmd_ready", 16'(cmd_ready), 16'd1);
        check("abort_we", 16'(mem_write_enable), 16'd0);
        check("abort_addr", 16'(mem_address), 16'd0);
        check("abort_wr_ready", 16'(wr_ready), 16'd0);
        check("abort_done", 16'(done), 16'd0);
        tick();
        wr_valid = 1'b0;
        check("abort_done_hold", 16'(done), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("abort_done_after", 16'(done), 16'd0);
        check_mem("mem_after_abort");

        // Next command runs normally
        load_burst(4'd10, 1);
        load_burst(4'd2, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
